// File: rtl/pu_race_engine.sv
// Four-lane race: lanes count down in lockstep until one or none remain.
// Ports: clk/rst_n, start+din0..3 in; puN_zero, busy, done, winner, tie, steps out.
module pu_race_engine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  input  logic [7:0] din2,
  input  logic [7:0] din3,
  output logic       pu0_zero,
  output logic       pu1_zero,
  output logic       pu2_zero,
  output logic       pu3_zero,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       tie,
  output logic [7:0] steps
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [3:0][7:0]  lane;
  logic [3:0]       nz;
  logic [2:0]       nz_cnt;
  logic [1:0]       last_idx;
  logic             terminal;

  always_comb begin
    nz_cnt   = '0;
    last_idx = '0;
    for (int i = 0; i < 4; i++) begin
      nz[i] = (lane[i] != 8'd0);
      nz_cnt = nz_cnt + {2'b00, nz[i]};
      if (nz[i]) last_idx = 2'(i);
    end
    terminal = (nz_cnt <= 3'd1);
  end

  assign pu0_zero = ~nz[0];
  assign pu1_zero = ~nz[1];
  assign pu2_zero = ~nz[2];
  assign pu3_zero = ~nz[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lane   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      winner <= '0;
      tie    <= 1'b0;
      steps  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lane  <= {din3, din2, din1, din0};
            steps <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (terminal) begin
            // last_idx is only meaningful with one survivor
            winner <= (nz_cnt == 3'd0) ? 2'd0 : last_idx;
            tie    <= (nz_cnt == 3'd0);
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (nz[i]) lane[i] <= lane[i] - 8'd1;
            end
            steps <= steps + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_race_engine.sv
// Self-checking bench for pu_race_engine.
// Directed table, hand sequences and random races against a sorting model.
module tb_pu_race_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] din0, din1, din2, din3;
  logic       pu0_zero, pu1_zero, pu2_zero, pu3_zero;
  logic       busy, done, tie;
  logic [1:0] winner;
  logic [7:0] steps;

  int n_chk;
  int n_fail;

  pu_race_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .pu0_zero(pu0_zero), .pu1_zero(pu1_zero),
    .pu2_zero(pu2_zero), .pu3_zero(pu3_zero),
    .busy(busy), .done(done), .winner(winner),
    .tie(tie), .steps(steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] d;
    logic [1:0]      w;
    logic            t;
    logic [7:0]      s;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the race lasts as long as the second-largest value.
  task automatic model(input logic [3:0][7:0] d, output logic [1:0] w,
                       output logic t, output logic [7:0] s);
    int mx, cnt, sec, am;
    mx = 0; cnt = 0; sec = 0; am = 0;
    for (int i = 0; i < 4; i++)
      if (int'(d[i]) > mx) begin mx = int'(d[i]); am = i; end
    for (int i = 0; i < 4; i++)
      if (int'(d[i]) == mx) cnt++;
    if (cnt >= 2) sec = mx;
    else
      for (int i = 0; i < 4; i++)
        if (i != am && int'(d[i]) > sec) sec = int'(d[i]);
    s = 8'(sec);
    if (cnt == 1) begin w = 2'(am); t = 1'b0; end
    else begin w = 2'd0; t = 1'b1; end
  endtask

  task automatic set_din(input logic [3:0][7:0] d);
    din0 = d[0]; din1 = d[1]; din2 = d[2]; din3 = d[3];
  endtask

  task automatic chk_zero(input logic [3:0][7:0] d, input logic [7:0] s);
    chk("pu0_zero", 32'(pu0_zero), 32'(d[0] <= s));
    chk("pu1_zero", 32'(pu1_zero), 32'(d[1] <= s));
    chk("pu2_zero", 32'(pu2_zero), 32'(d[2] <= s));
    chk("pu3_zero", 32'(pu3_zero), 32'(d[3] <= s));
  endtask

  task automatic run_race(input logic [3:0][7:0] d, input logic [1:0] ew,
                          input logic et, input logic [7:0] es,
                          input bit pulse_busy);
    int n;
    bit got;
    logic [3:0][7:0] junk;
    junk = {8'd0, 8'd0, 8'd0, 8'd1};
    @(negedge clk);
    set_din(d);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    chk("steps_clr", 32'(steps), 32'd0);
    n = 0;
    got = 1'b0;
    while (!got && n < 600) begin
      if (pulse_busy && (n == 4 || n == 99)) begin
        start = 1'b1;
        set_din(junk);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
      #1;
      got = done;
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(n), 32'(es) + 32'd1);
      chk("winner", 32'(winner), 32'(ew));
      chk("tie", 32'(tie), 32'(et));
      chk("steps", 32'(steps), 32'(es));
      chk("busy_done", 32'(busy), 32'd1);
      chk_zero(d, es);
    end
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", 32'(done), 32'd0);
    chk("hold_res", {22'd0, winner, tie, steps}, {22'd0, ew, et, es});
    chk_zero(d, es);
  endtask

  initial begin
    logic [3:0][7:0] d;
    logic [1:0] w;
    logic t;
    logic [7:0] s;
    logic [3:0][7:0] bb [3];
    int n;
    bit got;
    int lim;

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;

    tbl[0] = '{d: {8'd0, 8'd0, 8'd3, 8'd5}, w: 2'd0, t: 1'b0, s: 8'd3};
    tbl[1] = '{d: {8'd1, 8'd7, 8'd2, 8'd7}, w: 2'd0, t: 1'b1, s: 8'd7};
    tbl[2] = '{d: {8'd0, 8'd0, 8'd0, 8'd0}, w: 2'd0, t: 1'b1, s: 8'd0};
    tbl[3] = '{d: {8'd0, 8'd9, 8'd0, 8'd0}, w: 2'd2, t: 1'b0, s: 8'd0};
    tbl[4] = '{d: {8'd255, 8'd0, 8'd0, 8'd0}, w: 2'd3, t: 1'b0, s: 8'd0};
    tbl[5] = '{d: {8'd1, 8'd1, 8'd1, 8'd1}, w: 2'd0, t: 1'b1, s: 8'd1};
    tbl[6] = '{d: {8'd40, 8'd30, 8'd20, 8'd10}, w: 2'd3, t: 1'b0, s: 8'd30};
    tbl[7] = '{d: {8'd0, 8'd0, 8'd6, 8'd0}, w: 2'd1, t: 1'b0, s: 8'd0};
    tbl[8] = '{d: {8'd2, 8'd255, 8'd254, 8'd3}, w: 2'd2, t: 1'b0, s: 8'd254};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", {22'd0, winner, tie, steps}, 32'd0);
    chk("rst_zero", {28'd0, pu3_zero, pu2_zero, pu1_zero, pu0_zero}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_race(tbl[i].d, tbl[i].w, tbl[i].t, tbl[i].s, 1'b0);

    // start pulses while busy must be dropped
    run_race({8'd0, 8'd0, 8'd199, 8'd200}, 2'd0, 1'b0, 8'd199, 1'b1);

    // reset mid-race
    @(negedge clk);
    set_din({8'd20, 8'd30, 8'd40, 8'd50});
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_res", {22'd0, winner, tie, steps}, 32'd0);
    chk("mid_rst_zero",
        {28'd0, pu3_zero, pu2_zero, pu1_zero, pu0_zero}, 32'hF);
    @(posedge clk);
    #1;
    chk("mid_rst_nodone", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_race({8'd0, 8'd0, 8'd2, 8'd1}, 2'd1, 1'b0, 8'd1, 1'b0);

    // back-to-back with start held high
    bb[0] = {8'd0, 8'd0, 8'd1, 8'd3};
    bb[1] = {8'd0, 8'd0, 8'd0, 8'd0};
    bb[2] = {8'd0, 8'd2, 8'd4, 8'd4};
    @(negedge clk);
    set_din(bb[0]);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("b2b_capture", 32'(busy), 32'd1);
      chk("b2b_steps0", 32'(steps), 32'd0);
      model(bb[i], w, t, s);
      set_din(bb[(i + 1) % 3]);
      n = 0;
      got = 1'b0;
      while (!got && n < 600) begin
        @(posedge clk);
        n++;
        #1;
        got = done;
      end
      chk("b2b_latency", 32'(n), 32'(s) + 32'd1);
      chk("b2b_res", {22'd0, winner, tie, steps}, {22'd0, w, t, s});
      @(posedge clk);
      #1;
      chk("b2b_gap_done", 32'(done), 32'd0);
      chk("b2b_gap_idle", 32'(busy), 32'd0);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);

    // random races
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0: lim = 3;
        1: lim = 20;
        default: lim = 255;
      endcase
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, lim));
      if ($urandom_range(0, 3) == 0) d[1] = d[3];
      model(d, w, t, s);
      run_race(d, w, t, s, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
